// File: rtl/video_timing_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : video_timing_pkg                                                 |
// | Brief    : Shared types and constants for the raster timing generator:      |
// |            vertical region encoding, standard mode parameter sets, and the  |
// |            colour-bar table used by the optional test pattern.              |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package video_timing_pkg;

    typedef enum logic [1:0] {
        VR_ACT    = 2'd0,
        VR_FPORCH = 2'd1,
        VR_SYNC   = 2'd2,
        VR_BPORCH = 2'd3
    } v_region_t;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } timing_t;

    localparam timing_t c_timing_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        hs_pol: 1'b0,  vs_pol: 1'b0
    };

    localparam timing_t c_timing_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol: 1'b1,  vs_pol: 1'b1
    };

    // {r,g,b} on/off per bar, index 0 is the leftmost bar: W,Y,C,G,M,R,B,K
    localparam logic [7:0][2:0] c_color_bars = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return c_color_bars[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_delay_line.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : video_delay_line                                                 |
// | Brief    : WIDTH x DEPTH shift register with async active-low reset value;  |
// |            DEPTH=0 collapses to a plain wire.                               |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module video_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : video_timing_gen                                                 |
// | Brief    : Raster timing generator and pixel output stage; realigns renderer|
// |            RGB with DE/HSYNC/VSYNC across PIPE_LAT cycles of latency.       |
// |            Optional colour-bar test pattern: define VIDEO_TESTPAT_EN.       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = int'(c_timing_640x480_60.h_active),
    parameter int H_FP     = int'(c_timing_640x480_60.h_fp),
    parameter int H_SYNC   = int'(c_timing_640x480_60.h_sync),
    parameter int H_BP     = int'(c_timing_640x480_60.h_bp),
    parameter int V_ACTIVE = int'(c_timing_640x480_60.v_active),
    parameter int V_FP     = int'(c_timing_640x480_60.v_fp),
    parameter int V_SYNC   = int'(c_timing_640x480_60.v_sync),
    parameter int V_BP     = int'(c_timing_640x480_60.v_bp),
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int PIPE_LAT = 2,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic               clk_pix,
    input  logic               reset_n,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               pix_req,
    output logic               frame_start,
    output logic               line_start,
`ifdef VIDEO_TESTPAT_EN
    input  logic               tpg_on,
`endif
    input  logic [COLOR_W-1:0] pix_red,
    input  logic [COLOR_W-1:0] pix_green,
    input  logic [COLOR_W-1:0] pix_blue,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_de,
    output logic [COLOR_W-1:0] vga_red,
    output logic [COLOR_W-1:0] vga_green,
    output logic [COLOR_W-1:0] vga_blue
);

    localparam logic [XW-1:0] c_h_last      = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] c_h_act_end   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] c_hs_start    = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] c_hs_end      = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] c_v_act_last  = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] c_v_fp_last   = YW'(V_ACTIVE + V_FP - 1);
    localparam logic [YW-1:0] c_v_sync_last = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [YW-1:0] c_v_last      = YW'(V_TOTAL - 1);

    logic [XW-1:0] r_h;
    logic [YW-1:0] r_v;
    v_region_t     r_vstate;
    v_region_t     w_vstate_next;
    logic          w_h_wrap, w_h_act, w_h_sync, w_v_act, w_v_sync;
    logic          r_hs_t, r_vs_t;

    assign w_h_wrap = (r_h == c_h_last);
    assign w_h_act  = (r_h < c_h_act_end);
    assign w_h_sync = (r_h >= c_hs_start) && (r_h < c_hs_end);

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) r_vstate <= VR_ACT;
        else          r_vstate <= w_vstate_next;
    end

    // Region changes only on the line wrap, so vsync edges coincide with the h wrap
    always_comb begin
        w_vstate_next = r_vstate;
        if (w_h_wrap) begin
            case (r_vstate)
                VR_ACT:    if (r_v == c_v_act_last)  w_vstate_next = VR_FPORCH;
                VR_FPORCH: if (r_v == c_v_fp_last)   w_vstate_next = VR_SYNC;
                VR_SYNC:   if (r_v == c_v_sync_last) w_vstate_next = VR_BPORCH;
                VR_BPORCH: if (r_v == c_v_last)      w_vstate_next = VR_ACT;
                default:                             w_vstate_next = VR_ACT;
            endcase
        end
    end

    always_comb begin
        w_v_act  = (r_vstate == VR_ACT);
        w_v_sync = (r_vstate == VR_SYNC);
    end

    // Request stage: pix_req doubles as the raw data enable for time t
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            pix_x       <= '0;
            pix_y       <= '0;
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            r_hs_t      <= 1'b0;
            r_vs_t      <= 1'b0;
        end else begin
            pix_x       <= r_h;
            pix_y       <= r_v;
            pix_req     <= w_h_act && w_v_act;
            frame_start <= (r_h == '0) && (r_v == '0);
            line_start  <= (r_h == '0);
            r_hs_t      <= w_h_sync;
            r_vs_t      <= w_v_sync;
        end
    end

    logic w_hs_d, w_vs_d, w_de_d;
    logic [COLOR_W-1:0] w_red, w_green, w_blue;

`ifdef VIDEO_TESTPAT_EN
    localparam int            c_pipe_w = XW + 3;
    localparam logic [XW-1:0] c_bar_w  = XW'(H_ACTIVE / 8);
    logic [c_pipe_w-1:0] w_pipe_in, w_pipe_out;
    logic [XW-1:0]       w_x_d, w_bar_full;
    logic [2:0]          w_bar;
    assign w_pipe_in                        = {pix_x, r_hs_t, r_vs_t, pix_req};
    assign {w_x_d, w_hs_d, w_vs_d, w_de_d}  = w_pipe_out;
    assign w_bar_full                       = w_x_d / c_bar_w;
    assign w_bar                            = bar_rgb(w_bar_full[2:0]);
`else
    localparam int c_pipe_w = 3;
    logic [c_pipe_w-1:0] w_pipe_in, w_pipe_out;
    assign w_pipe_in                 = {r_hs_t, r_vs_t, pix_req};
    assign {w_hs_d, w_vs_d, w_de_d}  = w_pipe_out;
`endif

    video_delay_line #(
        .WIDTH     (c_pipe_w),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL ('0)
    ) u_pipe (
        .clk   (clk_pix),
        .rst_n (reset_n),
        .i_d   (w_pipe_in),
        .o_q   (w_pipe_out)
    );

    always_comb begin
        w_red   = pix_red;
        w_green = pix_green;
        w_blue  = pix_blue;
`ifdef VIDEO_TESTPAT_EN
        if (tpg_on) begin
            w_red   = {COLOR_W{w_bar[2]}};
            w_green = {COLOR_W{w_bar[1]}};
            w_blue  = {COLOR_W{w_bar[0]}};
        end
`endif
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            vga_de    <= 1'b0;
            vga_hsync <= ~HS_POL;
            vga_vsync <= ~VS_POL;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else begin
            vga_de    <= w_de_d;
            vga_hsync <= w_hs_d ^ ~HS_POL;
            vga_vsync <= w_vs_d ^ ~VS_POL;
            vga_red   <= w_de_d ? w_red   : '0;
            vga_green <= w_de_d ? w_green : '0;
            vga_blue  <= w_de_d ? w_blue  : '0;
        end
    end

endmodule
`default_nettype wire
